// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: VGA scanout owns active-video cycles, two
// auxiliary requesters share blanking round-robin; returns are steered by tag.
module fb_read_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RD_LAT   = 1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              vga_pvalid
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_R0   = 2'd2,
    TAG_R1   = 2'd3
  } tag_t;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  logic              w_active;
  logic [ADDR_W-1:0] w_vgaAddr;
  tag_t              w_issueTag;
  logic              r_ptr;
  tag_t              r_tag [RD_LAT+1];

  assign w_active  = (row < V_LIM) && (col < H_LIM);
  assign w_vgaAddr = ADDR_W'(row) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);

  // Blanking cycles only; the pointer breaks ties when both requesters wait.
  always_comb begin
    gnt = 2'b00;
    if (!reset && !w_active) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    w_issueTag = TAG_NONE;
    if (gnt[0])
      w_issueTag = TAG_R0;
    else if (gnt[1])
      w_issueTag = TAG_R1;
    else if (w_active)
      w_issueTag = TAG_VGA;
  end

  // Tags travel alongside the BRAM read so the returning word lands with its owner.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      fb_addr    <= '0;
      r_ptr      <= 1'b0;
      rvalid     <= 2'b00;
      rdata      <= '0;
      vga_pixel  <= '0;
      vga_pvalid <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++)
        r_tag[i] <= TAG_NONE;
    end else begin
      if (gnt[0])
        fb_addr <= req_addr0;
      else if (gnt[1])
        fb_addr <= req_addr1;
      else
        fb_addr <= w_vgaAddr;

      if (gnt[0])
        r_ptr <= 1'b1;
      else if (gnt[1])
        r_ptr <= 1'b0;

      r_tag[0] <= w_issueTag;
      for (int i = 1; i <= RD_LAT; i++)
        r_tag[i] <= r_tag[i-1];

      rvalid     <= 2'b00;
      vga_pvalid <= 1'b0;
      case (r_tag[RD_LAT])
        TAG_VGA: begin
          vga_pixel  <= fb_rdata;
          vga_pvalid <= 1'b1;
        end
        TAG_R0: begin
          rdata  <= fb_rdata;
          rvalid <= 2'b01;
        end
        TAG_R1: begin
          rdata  <= fb_rdata;
          rvalid <= 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: reset, active blocking, blank grants,
// round-robin order, frame wrap and reset while reads are in flight.
module tb_fb_read_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;

  logic              clk_50 = 1'b0;
  logic              reset;
  logic [9:0]        row;
  logic [9:0]        col;
  logic [1:0]        req;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_rdata;
  logic [DATA_W-1:0] vga_pixel;
  logic              vga_pvalid;

  int testCount = 0;
  int failCount = 0;

  fb_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .H_ACTIVE(640), .V_ACTIVE(480), .RD_LAT(1)
  ) dut (
    .clk_50(clk_50), .reset(reset), .row(row), .col(col), .req(req),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .vga_pixel(vga_pixel), .vga_pvalid(vga_pvalid)
  );

  always #10 clk_50 = ~clk_50;

  // Contents are a fixed function of the address so expected pixels need no table.
  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return a[11:0] ^ 12'h5A3 ^ {5'b0, a[18:12]};
  endfunction

  always @(posedge clk_50) fb_rdata <= memWord(fb_addr);

  task automatic tick;
    @(posedge clk_50);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] r, input logic [9:0] c, input logic [1:0] q);
    row = r;
    col = c;
    req = q;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  logic [1:0] rrExp [6];

  initial begin
    rrExp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    reset = 1'b1;
    req_addr0 = '0;
    req_addr1 = '0;
    applyStimulus(10'd500, 10'd0, 2'b11);
    checkOutput("reset gnt", gnt, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("reset gnt held", gnt, 2'b00);
    end
    reset = 1'b0;
    applyStimulus(10'd500, 10'd0, 2'b00);
    checkOutput("post-reset fb_addr", fb_addr, 0);
    checkOutput("post-reset rvalid", rvalid, 2'b00);
    checkOutput("post-reset rdata", rdata, 0);
    checkOutput("post-reset vga_pixel", vga_pixel, 0);
    checkOutput("post-reset vga_pvalid", vga_pvalid, 0);

    // Active video: request ignored, VGA fetch of (10,100).
    req_addr0 = 19'd1234;
    applyStimulus(10'd10, 10'd100, 2'b01);
    checkOutput("active gnt", gnt, 2'b00);
    tick;
    applyStimulus(10'd500, 10'd0, 2'b00);
    checkOutput("active fb_addr", fb_addr, 6500);
    tick;
    tick;
    checkOutput("active vga_pvalid", vga_pvalid, 1);
    checkOutput("active vga_pixel", vga_pixel, memWord(19'd6500));
    checkOutput("active rvalid", rvalid, 2'b00);

    // Horizontal blank grant to requester 0.
    applyStimulus(10'd10, 10'd700, 2'b01);
    checkOutput("blank gnt", gnt, 2'b01);
    tick;
    applyStimulus(10'd500, 10'd0, 2'b00);
    checkOutput("blank fb_addr", fb_addr, 1234);
    tick;
    checkOutput("blank rvalid early", rvalid, 2'b00);
    tick;
    checkOutput("blank rvalid", rvalid, 2'b01);
    checkOutput("blank rdata", rdata, memWord(19'd1234));
    tick;
    checkOutput("blank rvalid pulse", rvalid, 2'b00);

    // Last active column blocks, first blank column grants.
    applyStimulus(10'd10, 10'd639, 2'b01);
    checkOutput("col639 gnt", gnt, 2'b00);
    applyStimulus(10'd10, 10'd640, 2'b01);
    checkOutput("col640 gnt", gnt, 2'b01);
    tick;
    req_addr1 = 19'd777;
    applyStimulus(10'd500, 10'd0, 2'b10);
    checkOutput("req1 gnt", gnt, 2'b10);
    tick;
    applyStimulus(10'd500, 10'd0, 2'b00);
    checkOutput("req1 fb_addr", fb_addr, 777);
    tick;
    checkOutput("col640 rvalid", rvalid, 2'b01);
    tick;
    checkOutput("req1 rvalid", rvalid, 2'b10);
    checkOutput("req1 rdata", rdata, memWord(19'd777));

    // Both requesting through vertical blank alternates starting at requester 0.
    req_addr0 = 19'd100;
    req_addr1 = 19'd200;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        applyStimulus(10'd490, 10'(i * 3), 2'b11);
        checkOutput("rr gnt", gnt, rrExp[i]);
      end else begin
        applyStimulus(10'd490, 10'd0, 2'b00);
      end
      if (i >= 3) begin
        checkOutput("rr rvalid", rvalid, rrExp[i-3]);
        checkOutput("rr rdata", rdata,
                    (rrExp[i-3] == 2'b01) ? memWord(19'd100) : memWord(19'd200));
      end
      tick;
    end

    // Grant on the last blank cycle of the frame, then wrap to (0,0).
    req_addr0 = 19'd4321;
    applyStimulus(10'd524, 10'd799, 2'b01);
    checkOutput("wrap gnt", gnt, 2'b01);
    tick;
    applyStimulus(10'd0, 10'd0, 2'b01);
    checkOutput("wrap first active gnt", gnt, 2'b00);
    checkOutput("wrap fb_addr", fb_addr, 4321);
    tick;
    applyStimulus(10'd0, 10'd1, 2'b00);
    checkOutput("wrap vga fb_addr", fb_addr, 0);
    tick;
    applyStimulus(10'd500, 10'd0, 2'b00);
    checkOutput("wrap rvalid", rvalid, 2'b01);
    checkOutput("wrap rdata", rdata, memWord(19'd4321));
    checkOutput("wrap vga_pvalid early", vga_pvalid, 0);
    tick;
    checkOutput("wrap vga_pvalid", vga_pvalid, 1);
    checkOutput("wrap vga_pixel 0", vga_pixel, memWord(19'd0));
    checkOutput("wrap rvalid pulse", rvalid, 2'b00);
    tick;
    checkOutput("wrap vga_pixel 1", vga_pixel, memWord(19'd1));
    tick;
    checkOutput("wrap vga_pvalid end", vga_pvalid, 0);

    // Reset one cycle after a grant cancels the return.
    req_addr0 = 19'd999;
    applyStimulus(10'd500, 10'd0, 2'b01);
    checkOutput("midflight gnt", gnt, 2'b01);
    tick;
    reset = 1'b1;
    applyStimulus(10'd500, 10'd0, 2'b00);
    checkOutput("midflight fb_addr", fb_addr, 999);
    tick;
    reset = 1'b0;
    #1;
    checkOutput("midflight reset fb_addr", fb_addr, 0);
    checkOutput("midflight reset rvalid", rvalid, 2'b00);
    tick;
    checkOutput("midflight no rvalid", rvalid, 2'b00);
    tick;
    checkOutput("midflight no rvalid later", rvalid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Arbiter for the camera frame buffer's single read port (port B of the BRAM written by the OV7670 capture path). VGA scanout owns the port for every active-video pixel. Two auxiliary requesters share all blanking cycles round-robin: requester 0 is the face/box tracker and requester 1 is the snapshot dumper. Returned data is tagged through a pipeline and steered to its owner, so the VGA colour mux and the requesters never drive the BRAM address directly.

## Interface
Parameters:
- ADDR_W, 19, frame-buffer address width
- DATA_W, 12, pixel width ({B,G,R} 4 bits each)
- H_ACTIVE, 640, active columns; also the row stride for VGA address generation
- V_ACTIVE, 480, active rows
- RD_LAT, 1, BRAM read latency in clk_50 cycles (1..3)

Ports:
- clk_50  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- row  in  10  current VGA row from the sync counter
- col  in  10  current VGA column from the sync counter
- req[1:0]  in  2  per-requester read request; held until granted
- req_addr0, req_addr1  in  ADDR_W each  address for requester 0/1; stable while req is high
- gnt[1:0]  out  2  one-hot grant, combinational; at most one bit set
- rvalid[1:0]  out  2  one-cycle pulse, data for requester 0/1 on rdata
- rdata  out  DATA_W  returned pixel, shared by both requesters
- fb_addr  out  ADDR_W  registered BRAM port-B address
- fb_rdata  in  DATA_W  BRAM port-B data
- vga_pixel  out  DATA_W  registered pixel for the VGA colour mux
- vga_pvalid  out  1  vga_pixel holds an active-region fetch

## Operation
- active = (row < V_ACTIVE) && (col < H_ACTIVE). window = !active.
- One issue slot per cycle. The slot owner is decided combinationally each cycle:
  - active: VGA. gnt = 0 regardless of req.
  - window, req == 0: idle.
  - window, one req bit set: grant that bit.
  - window, both bits set: grant the requester indicated by the priority pointer ptr.
- ptr resets to 0. On any grant to requester k, ptr <= ~k for the next cycle.
- Issue register (fb_addr) on each edge:
  - VGA slot or idle: row*H_ACTIVE + col, computed at ADDR_W width with no truncation for row ≤ 524.
  - Grant k: req_addrk.
- Tag pipeline is RD_LAT+1 deep, 2-bit tag per stage:
  - NONE: idle, or VGA slot while inactive.
  - VGA: active slot.
  - R0, R1: grant to requester 0/1.
  - Tags advance every cycle and never stall.
- Output stage, registered, driven by the tag leaving the pipeline together with fb_rdata:
  - VGA: vga_pixel <= fb_rdata, vga_pvalid <= 1.
  - Rk: rdata <= fb_rdata, rvalid[k] <= 1.
  - Otherwise: vga_pvalid and rvalid go 0. vga_pixel and rdata hold their previous values.
- A request seen during active is simply not granted. The requester waits with no loss and no counting.

## Timing
- Reset values: fb_addr = 0, vga_pixel = 0, vga_pvalid = 0, rvalid = 0, rdata = 0, ptr = 0, all tags NONE.
- gnt is combinational and forced to 0 while reset is high.
- Grant in cycle t:
  - fb_addr = req_addr during t+1.
  - fb_rdata valid during t+1+RD_LAT.
  - rvalid and rdata during t+2+RD_LAT.
- VGA position (r,c) sampled in cycle t: vga_pixel/vga_pvalid during t+2+RD_LAT. Downstream sync delay must match 2+RD_LAT.
- Throughput: one grant per window cycle. A requester holding req high continuously gets back-to-back grants when it is the only one requesting.
- Window boundaries:
  - First active cycle after blanking: gnt = 0 even if req was granted the previous cycle.
  - First cycle with col == H_ACTIVE: grants are allowed.
- Data already in flight always completes across window boundaries and is never cancelled by a window change.
- Reset asserted mid-flight: all tags clear on that edge. No rvalid or vga_pvalid pulse follows for reads issued before reset.

## Test plan
- Reset: hold reset 3 cycles while req = 2'b11 at row 500 → gnt = 0 throughout. All outputs are 0 on the first cycle after release.
- Active blocking: row = 10, col = 100, req0 high → gnt = 0. fb_addr = 6500 one cycle later. With RD_LAT = 1, vga_pvalid = 1 and vga_pixel = BRAM[6500] three cycles after sampling.
- Blank grant: row = 10, col = 700, req_addr0 = 1234 → gnt = 2'b01 same cycle. fb_addr = 1234 next cycle. rvalid = 2'b01 with rdata = BRAM[1234] at t+3 (RD_LAT = 1).
- Round-robin: req = 2'b11 held through 6 vertical-blank cycles → gnt sequence 01, 10, 01, 10, 01, 10. rvalid follows the same order with 3-cycle offset.
- Boundary: grant at col = 799 of row 524 → next cycle is row 0, col 0 and gnt = 0. The granted read still returns rvalid 2 cycles later, and the VGA fetch of (0,0) returns with vga_pvalid.
- Reset mid-flight: grant at t, reset at t+1 → no rvalid at t+3, and fb_addr = 0 after the reset edge.
